serial_adder_ctrl: RTL and testbench
====================================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin one addition; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A; captured on accepted start.
REQ-006 b  input  WIDTH  operand B; captured on accepted start.
REQ-007 ci  input  1  carry-in; captured on accepted start.
REQ-008 busy  output  1  high while an addition is in progress (RUN state).
REQ-009 done  output  1  one-cycle pulse when sum/co become valid.
REQ-010 sum  output  WIDTH  result; holds its value from done until the next accepted start.
REQ-011 co  output  1  carry-out of the MSB; same validity as sum.

Function
REQ-012 Datapath SHALL be exactly one instance of the team's fulladder_half cell, time-multiplexed over the operand bits, LSB first.
REQ-013 FSM states: IDLE, RUN, DONE; encoding is free.
REQ-014 IDLE: start=1 -> capture a, b and ci into the shift/carry registers, clear the bit counter, go to RUN; start=0 -> stay in IDLE.
REQ-015 RUN: each cycle, add operand bit i with the carry register, shift the sum bit into the result register at the MSB end (right shift), update the carry register with the cell's co, and increment the counter.
REQ-016 RUN -> DONE on the cycle that processes bit WIDTH-1; RUN therefore lasts exactly WIDTH cycles.
REQ-017 DONE: assert done for one cycle, present the final sum and co, then go to IDLE unconditionally.
REQ-018 Latency: start sampled at edge k -> done high in the cycle following edge k+WIDTH; throughput is one addition per WIDTH+2 cycles.
REQ-019 start while in RUN or DONE is ignored: no queueing, and the operation in flight is unaffected.
REQ-020 a, b and ci changing after capture do not affect the result.
REQ-021 sum and co change only at the edge entering DONE; they are not updated during RUN.
REQ-022 Arithmetic: {co,sum} = a + b + ci, unsigned, modulo 2^(WIDTH+1).
REQ-023 busy is a registered decode of state == RUN; done is a registered decode of state == DONE; there are no combinational input-to-output paths.

Reset
REQ-024 When rst_n is low: state = IDLE, counter = 0, carry register = 0, sum = 0, co = 0, busy = 0, done = 0 (ovf = 0 when present).
REQ-025 Reset asserted mid-RUN SHALL abort the operation immediately; no done pulse follows.
REQ-026 The first start is accepted at the first rising edge after rst_n deasserts.

Configuration
REQ-027 Macro SERIAL_ADD_OVF_EN, when defined, adds output ovf (1 bit): two's-complement signed overflow of a + b + ci.
REQ-028 ovf = (carry into MSB) XOR (carry out of MSB); it is valid, updated and held with the same timing as sum.
REQ-029 Without SERIAL_ADD_OVF_EN, the port and its logic are absent and all other behaviour is identical.

Verification
REQ-030 WIDTH=8, a=8'h5A, b=8'h3C, ci=0, start pulse -> busy high for 8 cycles, done at cycle 9, sum=8'h96, co=0 (ovf=1 when enabled).
REQ-031 a=8'hFF, b=8'h00, ci=1 -> sum=8'h00, co=1; a=8'h80, b=8'h80, ci=0 -> sum=8'h00, co=1, ovf=1.
REQ-032 start held high continuously with new operands -> results back-to-back every 10 cycles; a pulse in RUN with other operands leaves the current result unchanged.
REQ-033 rst_n pulled low in RUN cycle 4 -> all outputs 0, no done pulse; the next start completes correctly.
REQ-034 Operands changed every cycle during RUN -> result equals the sum of the values captured at start.
REQ-035 Random 1000-operation regression at WIDTH=4 and WIDTH=16 -> {co,sum} matches the reference model on every done.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one fulladder_half cell reused LSB first over WIDTH cycles.
// Define SERIAL_ADD_OVF_EN to add the signed-overflow output ovf.
module fulladder_half (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
    output logic             ovf,
`endif
    output logic             co
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             co_q, co_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic fa_s;
    logic fa_co;
    logic last_bit;

    fulladder_half u_fa (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_bit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        sum_d   = sum_q;
        co_d    = co_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        if (state_q == S_IDLE && start) begin
            a_sh_d  = a;
            b_sh_d  = b;
            carry_d = ci;
            cnt_d   = '0;
        end else if (state_q == S_RUN) begin
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            res_d   = {fa_s, res_q[WIDTH-1:1]};
            carry_d = fa_co;
            cnt_d   = cnt_q + CW'(1);
            // Outputs move only on the MSB cycle so they hold through RUN.
            if (last_bit) begin
                sum_d = {fa_s, res_q[WIDTH-1:1]};
                co_d  = fa_co;
`ifdef SERIAL_ADD_OVF_EN
                ovf_d = carry_q ^ fa_co;
`endif
            end
        end
    end

    always_comb begin
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign co   = co_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH 8, 4 and 16.
// Build with SERIAL_ADD_OVF_EN defined to also check ovf.
module tb_serial_adder_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    logic       st8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       ci8 = 1'b0;
    logic       busy8, done8, co8;
    logic [7:0] sum8;

    logic       st4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       ci4 = 1'b0;
    logic       busy4, done4, co4;
    logic [3:0] sum4;

    logic        st16 = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        ci16 = 1'b0;
    logic        busy16, done16, co16;
    logic [15:0] sum16;

`ifdef SERIAL_ADD_OVF_EN
    logic ovf8, ovf4, ovf16;
`endif

    serial_adder_ctrl #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(st8),
        .a(a8), .b(b8), .ci(ci8),
        .busy(busy8), .done(done8), .sum(sum8),
`ifdef SERIAL_ADD_OVF_EN
        .ovf(ovf8),
`endif
        .co(co8)
    );

    serial_adder_ctrl #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(st4),
        .a(a4), .b(b4), .ci(ci4),
        .busy(busy4), .done(done4), .sum(sum4),
`ifdef SERIAL_ADD_OVF_EN
        .ovf(ovf4),
`endif
        .co(co4)
    );

    serial_adder_ctrl #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .start(st16),
        .a(a16), .b(b16), .ci(ci16),
        .busy(busy16), .done(done16), .sum(sum16),
`ifdef SERIAL_ADD_OVF_EN
        .ovf(ovf16),
`endif
        .co(co16)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the captured operands.
    function automatic longint ref_tot(input longint x, input longint y,
                                       input longint c);
        return x + y + c;
    endfunction

    function automatic bit ref_ovf(input int w, input longint x,
                                   input longint y, input longint c);
        longint lim, sx, sy, s;
        lim = longint'(1) << (w - 1);
        sx = (x >= lim) ? x - 2 * lim : x;
        sy = (y >= lim) ? y - 2 * lim : y;
        s = sx + sy + c;
        return (s >= lim) || (s < -lim);
    endfunction

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    vec_t tbl[6];

    // Call at a negedge with the DUT idle; returns at a negedge, idle.
    task automatic op8(input vec_t v, input string tag, input bit disturb);
        int nbusy;
        bit moved;
        logic [7:0] hs;
        logic hc;
        nbusy = 0;
        moved = 0;
        hs = sum8;
        hc = co8;
        a8 = v.a;
        b8 = v.b;
        ci8 = v.ci;
        st8 = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            st8 = 1'b0;
            if (disturb) begin
                a8 = 8'($urandom);
                b8 = 8'($urandom);
                ci8 = 1'($urandom);
                st8 = i[0];
            end
            if (busy8 && !done8) nbusy++;
            if (sum8 !== hs || co8 !== hc) moved = 1;
        end
        @(negedge clk);
        st8 = 1'b0;
        chk({tag, " busy cycles"}, 64'(nbusy), 64'd8);
        chk({tag, " held in run"}, 64'(moved), 64'd0);
        chk({tag, " done/busy"}, {done8, busy8}, 2'b10);
        chk({tag, " sum"}, sum8, v.s);
        chk({tag, " co"}, co8, v.co);
`ifdef SERIAL_ADD_OVF_EN
        chk({tag, " ovf"}, ovf8, v.ov);
`endif
        @(negedge clk);
        chk({tag, " done pulse"}, done8, 1'b0);
        chk({tag, " sum hold"}, {co8, sum8}, {v.co, v.s});
    endtask

    task automatic rnd4();
        logic [3:0] x, y;
        logic c;
        bit got;
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            x = 4'($urandom);
            y = 4'($urandom);
            c = 1'($urandom);
            a4 = x;
            b4 = y;
            ci4 = c;
            st4 = 1'b1;
            got = 0;
            for (int t = 0; t < 12 && !got; t++) begin
                @(negedge clk);
                if (done4) got = 1;
                else begin
                    st4 = ($urandom_range(0, 3) == 0);
                    a4 = 4'($urandom);
                    b4 = 4'($urandom);
                    ci4 = 1'($urandom);
                end
            end
            st4 = 1'b0;
            chk("w4 done seen", 64'(got), 64'd1);
            chk("w4 result", {co4, sum4}, 64'(ref_tot(x, y, c)));
`ifdef SERIAL_ADD_OVF_EN
            chk("w4 ovf", ovf4, ref_ovf(4, x, y, c));
`endif
            @(negedge clk);
        end
    endtask

    task automatic rnd16();
        logic [15:0] x, y;
        logic c;
        bit got;
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            x = 16'($urandom);
            y = 16'($urandom);
            c = 1'($urandom);
            a16 = x;
            b16 = y;
            ci16 = c;
            st16 = 1'b1;
            got = 0;
            for (int t = 0; t < 24 && !got; t++) begin
                @(negedge clk);
                if (done16) got = 1;
                else begin
                    st16 = ($urandom_range(0, 3) == 0);
                    a16 = 16'($urandom);
                    b16 = 16'($urandom);
                    ci16 = 1'($urandom);
                end
            end
            st16 = 1'b0;
            chk("w16 done seen", 64'(got), 64'd1);
            chk("w16 result", {co16, sum16}, 64'(ref_tot(x, y, c)));
`ifdef SERIAL_ADD_OVF_EN
            chk("w16 ovf", ovf16, ref_ovf(16, x, y, c));
`endif
            @(negedge clk);
        end
    endtask

    initial begin
        vec_t bb[4];
        vec_t v;
        bit got;
        int last;

        tbl[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
        tbl[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[3] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
        tbl[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

        #12;
        chk("rst u8", {busy8, done8, co8, sum8}, 64'd0);
        chk("rst u4", {busy4, done4, co4, sum4}, 64'd0);
        chk("rst u16", {busy16, done16, co16, sum16}, 64'd0);
`ifdef SERIAL_ADD_OVF_EN
        chk("rst ovf", {ovf8, ovf4, ovf16}, 64'd0);
`endif

        // First start right at deassertion must be taken on the next edge.
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++)
            op8(tbl[i], $sformatf("tbl%0d", i), i[0]);

        // start held high: one result every WIDTH+2 cycles.
        bb[0] = '{8'h12, 8'h34, 1'b0, 8'h00, 1'b0, 1'b0};
        bb[1] = '{8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0};
        bb[2] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b0};
        bb[3] = '{8'h01, 8'hFE, 1'b0, 8'h00, 1'b0, 1'b0};
        a8 = bb[0].a;
        b8 = bb[0].b;
        ci8 = bb[0].ci;
        st8 = 1'b1;
        last = 0;
        for (int j = 0; j < 4; j++) begin
            got = 0;
            for (int t = 0; t < 20 && !got; t++) begin
                @(negedge clk);
                if (t == 3) begin
                    a8 = 8'($urandom);
                    b8 = 8'($urandom);
                    ci8 = 1'($urandom);
                end
                if (done8) got = 1;
            end
            chk($sformatf("b2b%0d done seen", j), 64'(got), 64'd1);
            chk($sformatf("b2b%0d result", j), {co8, sum8},
                64'(ref_tot(bb[j].a, bb[j].b, bb[j].ci)));
            if (j > 0)
                chk($sformatf("b2b%0d period", j), 64'(cyc - last), 64'd10);
            last = cyc;
            if (j < 3) begin
                a8 = bb[j+1].a;
                b8 = bb[j+1].b;
                ci8 = bb[j+1].ci;
            end else st8 = 1'b0;
        end

        // Reset in RUN cycle 4 aborts the operation.
        @(negedge clk);
        a8 = 8'h5A;
        b8 = 8'h3C;
        ci8 = 1'b0;
        st8 = 1'b1;
        repeat (4) begin
            @(negedge clk);
            st8 = 1'b0;
        end
        chk("abort busy before", busy8, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort outputs", {busy8, done8, co8, sum8}, 64'd0);
`ifdef SERIAL_ADD_OVF_EN
        chk("abort ovf", ovf8, 1'b0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        got = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) got = 1;
        end
        chk("abort no done", 64'(got), 64'd0);
        v = tbl[0];
        op8(v, "after abort", 1'b1);

        fork
            rnd4();
            rnd16();
        join

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
